cover_toggle_collector: RTL

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

---
 rtl/cover_pkg.sv | 15 +
 rtl/cover_toggle_collector_lowest_set_index.sv | 29 ++
 rtl/cover_toggle_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/cover_pkg.sv
// Shared definitions for the coverage collectors.
//   COVER_INDEX_W : width of a global cover index on the report bus
//   cover_index_t : global cover index type
//   idx_w()       : bit width needed to address n positions (minimum 1)
package cover_pkg;

  localparam int COVER_INDEX_W = 64;

  typedef logic [COVER_INDEX_W-1:0] cover_index_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cover_toggle_collector_lowest_set_index.sv
// Priority selector: finds the lowest-numbered set bit of a vector.
// Ports:
//   vec   in  WIDTH  candidate bits
//   found out 1      at least one bit of vec is set
//   index out IDX_W  position of the lowest set bit (0 when found is low)
module lowest_set_index
  import cover_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the last match written is the lowest bit.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector. Records which of WIDTH toggle points have been
// hit since reset or the last clear, and reports every newly covered point
// exactly once as a global cover index over a valid/ready bus.
// Ports:
//   clock       in  1                 sole clock, rising edge
//   reset       in  1                 synchronous active-high reset
//   valid       in  WIDTH             per-bit toggle-hit strobes
//   clear_cov   in  1                 forget all coverage, start a new epoch
//   out_valid   out 1                 report slot holds an unreported index
//   out_ready   in  1                 consumer accepts the report
//   out_index   out 64                COVER_INDEX + bit position of the report
//   hit_count   out $clog2(WIDTH+1)   distinct bits covered in this epoch
//   all_covered out 1                 every bit has been covered
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear_cov,
  output logic                       out_valid,
  input  logic                       out_ready,
  output cover_index_t               out_index,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_covered
);

  localparam int IDX_W = idx_w(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] take_mask;
  logic             slot_free;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IDX_W'(i) == idx) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Stage 1: hit capture. Only first hits on uncovered bits become pending,
  // so each bit is reported at most once per epoch.
  assign new_hits = valid & ~covered;

  lowest_set_index #(
    .WIDTH (WIDTH)
  ) u_sel (
    .vec   (pending),
    .found (sel_found),
    .index (sel_idx)
  );

  // Stage 2: report slot. It refills when empty or when the current report
  // is being accepted, which gives one transfer per cycle under ready.
  assign slot_free = !out_valid || out_ready;
  assign take_mask = (slot_free && sel_found) ? onehot(sel_idx) : '0;

  // Clear behaves like reset for the collection state; hits sampled in the
  // same cycle are dropped so the new epoch starts empty.
  always_ff @(posedge clock) begin
    if (reset || clear_cov) begin
      covered   <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
    end else begin
      covered   <= covered | valid;
      pending   <= (pending & ~take_mask) | new_hits;
      hit_count <= hit_count + popcount(new_hits);
      if (slot_free) begin
        out_valid <= sel_found;
        if (sel_found) begin
          out_index <= cover_index_t'(COVER_INDEX) + cover_index_t'(sel_idx);
        end
      end
    end
  end

  assign all_covered = (hit_count == CNT_W'(WIDTH));

  // Parameter sanity: this collector's index window must fit in the design.
  always @(posedge clock) begin
    if (!reset) begin
      assert (WIDTH >= 1 && WIDTH <= 1024);
      assert (COVER_INDEX + WIDTH <= COVER_TOTAL);
    end
  end

endmodule
